// File: rtl/mdr_control_unit_pkg.sv
// Shared types for the MDR sequencer: operand width, op codes, FSM states,
// iteration count type and the bundled control-output struct.
package pkg_mdr;

    localparam int DW = 16;
    localparam int CW = $clog2(DW) + 1;

    typedef logic [2:0] t_op;
    localparam t_op OP_MUL  = 3'd0;
    localparam t_op OP_DIV  = 3'd1;
    localparam t_op OP_SQRT = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAN,
        S_WAIT_X,
        S_WAIT_Y,
        S_INIT,
        S_VERIFICATION,
        S_CALCULATION,
        S_READY
    } state_t;

    typedef logic [CW-1:0] count_t;

    typedef struct packed {
        logic   load_x;
        logic   load_y;
        logic   ena_pipo;
        logic   ena_veri;
        logic   ena_mdr_mods;
        logic   clean;
        logic   ovf;
        logic   ready;
        t_op    op_o;
        count_t count;
    } control_t;

    function automatic logic op_valid(input t_op op);
        return op <= OP_SQRT;
    endfunction

    // Last iteration index: square root resolves two radicand bits per step.
    function automatic count_t iter_limit(input t_op op);
        return (op == OP_SQRT) ? count_t'(DW/2 - 1) : count_t'(DW - 1);
    endfunction

endpackage

// File: rtl/mdr_control_unit_if.sv
// Request/control bus between the user interface and the MDR sequencer.
// MDR_ABORT_EN adds the abort request line.
interface mdr_control_unit_if;
    import pkg_mdr::*;

`ifdef MDR_ABORT_EN
    logic   abort;
`endif
    logic   start;
    logic   load;
    t_op    op_i;
    logic   err_i;
    logic   load_x;
    logic   load_y;
    logic   ena_pipo;
    logic   ena_veri;
    logic   ena_mdr_mods;
    t_op    op_o;
    logic   clean;
    logic   ovf;
    logic   ready;
    count_t count;

    modport master (
`ifdef MDR_ABORT_EN
        output abort,
`endif
        output start, load, op_i, err_i,
        input  load_x, load_y, ena_pipo, ena_veri, ena_mdr_mods,
        input  op_o, clean, ovf, ready, count
    );

    modport slave (
`ifdef MDR_ABORT_EN
        input  abort,
`endif
        input  start, load, op_i, err_i,
        output load_x, load_y, ena_pipo, ena_veri, ena_mdr_mods,
        output op_o, clean, ovf, ready, count
    );

endinterface

// File: rtl/mdr_control_unit_counter.sv
// Iteration counter for the MDR sequencer: synchronous clear, enable,
// saturates at the supplied limit and flags it.
module mdr_iter_counter
    import pkg_mdr::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_clr,
    input  logic   i_en,
    input  count_t i_limit,
    output count_t o_count,
    output logic   o_done
);

    count_t r_count;

    // NOTE: async reset sits in the sensitivity list; state updates use <= so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != i_limit)) begin
            r_count <= r_count + count_t'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == i_limit);

endmodule

// File: rtl/mdr_control_unit.sv
// Sequencing FSM for the multiply/divide/square-root datapath.
// Optional MDR_ABORT_EN: abort returns any busy state to IDLE with a clean pulse.
module mdr_control_unit
    import pkg_mdr::*;
(
    input  logic                clk,
    input  logic                rst,
    mdr_control_unit_if.slave   bus
);

    state_t   r_state;
    t_op      r_op;
    logic     r_ovf;
    logic     r_ready;
    logic     r_clean;
    logic     r_ena_pipo;
    logic     r_ena_veri;
    logic     r_ena_mdr;

    logic     w_abort;
    logic     w_clr;
    logic     w_en;
    logic     w_done;
    count_t   w_count;
    count_t   w_limit;
    control_t w_ctrl;

`ifdef MDR_ABORT_EN
    assign w_abort = bus.abort && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign w_limit = iter_limit(r_op);
    assign w_clr   = (r_state == S_INIT);
    assign w_en    = (r_state == S_CALCULATION);

    mdr_iter_counter u_iter_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .i_limit (w_limit),
        .o_count (w_count),
        .o_done  (w_done)
    );

    // Strobes default low each cycle and are raised on the edge entering the
    // state that owns them, so they line up with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_MUL;
            r_ovf      <= 1'b0;
            r_ready    <= 1'b0;
            r_clean    <= 1'b0;
            r_ena_pipo <= 1'b0;
            r_ena_veri <= 1'b0;
            r_ena_mdr  <= 1'b0;
        end else begin
            r_clean    <= 1'b0;
            r_ena_pipo <= 1'b0;
            r_ena_veri <= 1'b0;
            r_ena_mdr  <= 1'b0;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_clean <= 1'b1;
                r_ovf   <= 1'b0;
                r_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_READY: begin
                        if (bus.start) begin
                            r_state <= S_CLEAN;
                            r_op    <= bus.op_i;
                            r_ovf   <= 1'b0;
                            r_ready <= 1'b0;
                            r_clean <= 1'b1;
                        end
                    end
                    S_CLEAN: r_state <= S_WAIT_X;
                    S_WAIT_X: begin
                        if (bus.load) begin
                            if (r_op == OP_SQRT) begin
                                r_state    <= S_INIT;
                                r_ena_pipo <= 1'b1;
                            end else begin
                                r_state <= S_WAIT_Y;
                            end
                        end
                    end
                    S_WAIT_Y: begin
                        if (bus.load) begin
                            r_state    <= S_INIT;
                            r_ena_pipo <= 1'b1;
                        end
                    end
                    S_INIT: begin
                        r_state    <= S_VERIFICATION;
                        r_ena_veri <= 1'b1;
                    end
                    S_VERIFICATION: begin
                        if (bus.err_i || !op_valid(r_op)) begin
                            r_state <= S_READY;
                            r_ovf   <= 1'b1;
                            r_ready <= 1'b1;
                        end else begin
                            r_state    <= S_CALCULATION;
                            r_ena_mdr  <= 1'b1;
                            r_ena_pipo <= 1'b1;
                        end
                    end
                    S_CALCULATION: begin
                        if (w_done) begin
                            r_state <= S_READY;
                            r_ready <= 1'b1;
                        end else begin
                            r_ena_mdr  <= 1'b1;
                            r_ena_pipo <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // NOTE: every field gets a value before any condition, so no latch is inferred.
    always_comb begin
        w_ctrl              = '0;
        w_ctrl.load_x       = bus.load && !w_abort && (r_state == S_WAIT_X);
        w_ctrl.load_y       = bus.load && !w_abort && (r_state == S_WAIT_Y);
        w_ctrl.ena_pipo     = r_ena_pipo;
        w_ctrl.ena_veri     = r_ena_veri;
        w_ctrl.ena_mdr_mods = r_ena_mdr;
        w_ctrl.clean        = r_clean;
        w_ctrl.ovf          = r_ovf;
        w_ctrl.ready        = r_ready;
        w_ctrl.op_o         = r_op;
        w_ctrl.count        = w_count;
    end

    assign bus.load_x       = w_ctrl.load_x;
    assign bus.load_y       = w_ctrl.load_y;
    assign bus.ena_pipo     = w_ctrl.ena_pipo;
    assign bus.ena_veri     = w_ctrl.ena_veri;
    assign bus.ena_mdr_mods = w_ctrl.ena_mdr_mods;
    assign bus.clean        = w_ctrl.clean;
    assign bus.ovf          = w_ctrl.ovf;
    assign bus.ready        = w_ctrl.ready;
    assign bus.op_o         = w_ctrl.op_o;
    assign bus.count        = w_ctrl.count;

endmodule

// File: tb/tb_mdr_control_unit.sv
// Self-checking bench for mdr_control_unit: each operation is judged against
// a transaction-level model (latency, iteration count, error outcome).
module tb_mdr_control_unit;
    import pkg_mdr::*;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    mdr_control_unit_if bus ();

    mdr_control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] all_outputs();
        return {bus.load_x, bus.load_y, bus.ena_pipo, bus.ena_veri, bus.ena_mdr_mods,
                bus.clean, bus.ovf, bus.ready, bus.op_o, bus.count};
    endfunction

    // Full operation from IDLE/READY; expectations come from the op rules only.
    task automatic run_op(input t_op op, input logic err, input logic noisy,
                          input logic load_with_start);
        int   n;
        int   exp_lat;
        int   exp_mdr;
        int   got;
        int   mdr;
        int   w;
        logic exp_err;
        exp_err = err || (op > OP_SQRT);
        n       = (op == OP_SQRT) ? DW/2 : DW;
        exp_lat = exp_err ? 3 : n + 3;
        exp_mdr = exp_err ? 0 : n;
        bus.err_i = err;
        bus.start = 1'b1;
        bus.op_i  = op;
        bus.load  = load_with_start;
        @(negedge clk);
        bus.start = 1'b0;
        bus.load  = 1'b0;
        bus.op_i  = 3'($urandom);
        #1;
        vectors++;
        if ({bus.clean, bus.ready, bus.ovf, bus.load_x, bus.op_o} !== {4'b1000, op}) begin
            errors++;
            $display("FAIL clean_cycle: got clean/ready/ovf/load_x/op=%b expected %b",
                     {bus.clean, bus.ready, bus.ovf, bus.load_x, bus.op_o}, {4'b1000, op});
        end
        @(negedge clk);
        vectors++;
        if (bus.clean !== 1'b0) begin
            errors++;
            $display("FAIL clean_width: got clean=%b expected 0", bus.clean);
        end
        w = $urandom_range(0, 2);
        repeat (w) @(negedge clk);
        bus.load = 1'b1;
        #1;
        vectors++;
        if ({bus.load_x, bus.load_y} !== 2'b10) begin
            errors++;
            $display("FAIL load_x: got x/y=%b expected 10", {bus.load_x, bus.load_y});
        end
        @(negedge clk);
        bus.load = 1'b0;
        if (op != OP_SQRT) begin
            w = $urandom_range(0, 2);
            repeat (w) @(negedge clk);
            bus.load = 1'b1;
            #1;
            vectors++;
            if ({bus.load_x, bus.load_y} !== 2'b01) begin
                errors++;
                $display("FAIL load_y: got x/y=%b expected 01", {bus.load_x, bus.load_y});
            end
            @(negedge clk);
            bus.load = 1'b0;
        end
        got = -1;
        mdr = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.ready === 1'b1) begin
                got = k;
                break;
            end
            vectors++;
            if ({bus.op_o, bus.ovf} !== {op, 1'b0}) begin
                errors++;
                $display("FAIL busy_op: got op/ovf=%b expected %b", {bus.op_o, bus.ovf}, {op, 1'b0});
            end
            if (k == 1) begin
                vectors++;
                if ({bus.ena_pipo, bus.ena_veri, bus.ena_mdr_mods} !== 3'b100) begin
                    errors++;
                    $display("FAIL init_ctrl: got pipo/veri/mdr=%b expected 100",
                             {bus.ena_pipo, bus.ena_veri, bus.ena_mdr_mods});
                end
            end
            if (k == 2) begin
                vectors++;
                if ({bus.ena_pipo, bus.ena_veri, bus.ena_mdr_mods} !== 3'b010) begin
                    errors++;
                    $display("FAIL veri_ctrl: got pipo/veri/mdr=%b expected 010",
                             {bus.ena_pipo, bus.ena_veri, bus.ena_mdr_mods});
                end
            end
            if (bus.ena_mdr_mods === 1'b1) begin
                vectors++;
                if ({bus.ena_pipo, bus.count} !== {1'b1, count_t'(mdr)}) begin
                    errors++;
                    $display("FAIL calc_count: got pipo=%b count=%0d expected pipo=1 count=%0d",
                             bus.ena_pipo, bus.count, mdr);
                end
                mdr++;
            end
            if (noisy || k == 1) begin
                bus.start = noisy ? 1'($urandom) : 1'b0;
                bus.load  = 1'b1;
                #1;
                vectors++;
                if ({bus.load_x, bus.load_y} !== 2'b00) begin
                    errors++;
                    $display("FAIL stray_load: got x/y=%b expected 00", {bus.load_x, bus.load_y});
                end
            end
            @(negedge clk);
            bus.start = 1'b0;
            bus.load  = 1'b0;
        end
        vectors++;
        if (got != exp_lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected %0d (op=%0d err=%b)", got, exp_lat, op, err);
        end
        vectors++;
        if (mdr != exp_mdr) begin
            errors++;
            $display("FAIL iterations: got %0d expected %0d", mdr, exp_mdr);
        end
        vectors++;
        if (bus.ovf !== exp_err) begin
            errors++;
            $display("FAIL ovf: got %b expected %b", bus.ovf, exp_err);
        end
        if (!exp_err) begin
            vectors++;
            if (bus.count !== count_t'(n - 1)) begin
                errors++;
                $display("FAIL final_count: got %0d expected %0d", bus.count, n - 1);
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.ready, bus.ovf, bus.ena_mdr_mods} !== {1'b1, exp_err, 1'b0}) begin
            errors++;
            $display("FAIL ready_hold: got ready/ovf/mdr=%b expected %b",
                     {bus.ready, bus.ovf, bus.ena_mdr_mods}, {1'b1, exp_err, 1'b0});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (all_outputs() !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0000", all_outputs());
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        run_op(OP_MUL, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_sqrt();
        run_op(OP_SQRT, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_div_err();
        run_op(OP_DIV, 1'b1, 1'b0, 1'b0);
        run_op(OP_DIV, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_invalid_op();
        run_op(3'd5, 1'b0, 1'b1, 1'b0);
        run_op(OP_MUL, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_start_load_ready();
        run_op(OP_SQRT, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            run_op(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                   1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        logic hit;
        hit = 1'b0;
        bus.err_i = 1'b0;
        bus.op_i  = OP_DIV;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.load = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.load = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.ena_mdr_mods === 1'b1 && bus.count === count_t'(7)) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        vectors++;
        if (hit !== 1'b1) begin
            errors++;
            $display("FAIL reach_count7: got %b expected 1", hit);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (all_outputs() !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0000", all_outputs());
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (all_outputs() !== 16'h0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected 0000", all_outputs());
        end
        run_op(OP_MUL, 1'b0, 1'b0, 1'b0);
    endtask

`ifdef MDR_ABORT_EN
    task automatic test_abort();
        bus.err_i = 1'b0;
        bus.op_i  = OP_DIV;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.load = 1'b1;
        @(negedge clk);
        bus.load  = 1'b0;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        vectors++;
        if ({bus.clean, bus.ready, bus.ovf} !== 3'b100) begin
            errors++;
            $display("FAIL abort_clean: got clean/ready/ovf=%b expected 100",
                     {bus.clean, bus.ready, bus.ovf});
        end
        bus.load = 1'b1;
        #1;
        vectors++;
        if ({bus.load_x, bus.load_y} !== 2'b00) begin
            errors++;
            $display("FAIL abort_idle: got x/y=%b expected 00", {bus.load_x, bus.load_y});
        end
        @(negedge clk);
        bus.load = 1'b0;
        vectors++;
        if ({bus.clean, bus.ready, bus.ovf, bus.ena_pipo} !== 4'b0000) begin
            errors++;
            $display("FAIL abort_settle: got %b expected 0000",
                     {bus.clean, bus.ready, bus.ovf, bus.ena_pipo});
        end
        run_op(OP_MUL, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.load  = 1'b0;
        bus.op_i  = OP_MUL;
        bus.err_i = 1'b0;
`ifdef MDR_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_mul();
        test_sqrt();
        test_div_err();
        test_invalid_op();
        test_start_load_ready();
        test_random();
        test_reset_mid();
`ifdef MDR_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
